pipe_skid_reg: RTL



---
 rtl/pipe_pkg.sv | 33 +++
 rtl/pipe_slot.sv | 27 ++
 rtl/pipe_skid_reg.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage register.
// Holds the occupancy state enum, control-field bit positions and default widths.
package pipe_pkg;

  localparam int DATA_W_DEF = 48;
  localparam int CTRL_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  // Bit positions inside the control field carried alongside the payload.
  localparam int CTRL_HALT     = 0;
  localparam int CTRL_REGWR    = 1;
  localparam int CTRL_MEM2REG  = 2;
  localparam int CTRL_PCS      = 3;
  localparam int CTRL_WREG_LSB = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  function automatic logic [1:0] occ_of(input state_e s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      ONE:     occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One stage-register entry (control + payload) with a load enable.
// Instantiated twice by pipe_skid_reg: once as the main slot, once as the skid slot.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  // NOTE: sequential state uses non-blocking assignments only; this storage is
  // reset on purpose because zeroed outputs and skid contents are visible after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic valid/ready stage register with a 2-entry skid buffer, synchronous flush
// and control zeroing on bubbles. Optional saturating counters via PIPE_SKID_STATS_EN.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  localparam int ENT_W = CTRL_W + DATA_W;

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               in_fire, out_fire;
  logic               main_load, skid_load, main_from_skid;
  logic [ENT_W-1:0]   in_ent, main_d, main_ent, skid_ent;

  assign in_ent    = {in_ctrl, in_data};
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d        = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign main_d = main_from_skid ? skid_ent : in_ent;

  pipe_slot #(.W(ENT_W)) u_main (
    .clk    (clk),
    .rst_n  (rst),
    .load_i (main_load),
    .d_i    (main_d),
    .q_o    (main_ent)
  );

  pipe_slot #(.W(ENT_W)) u_skid (
    .clk    (clk),
    .rst_n  (rst),
    .load_i (skid_load),
    .d_i    (in_ent),
    .q_o    (skid_ent)
  );

  // A bubble must never assert regWrite/halt downstream, so gate control with valid.
  assign out_ctrl  = main_ent[ENT_W-1 -: CTRL_W] & {CTRL_W{out_valid}};
  assign out_data  = main_ent[DATA_W-1:0];
  assign in_ready  = in_ready_q;
  assign occupancy = occ_of(state_q);

`ifdef PIPE_SKID_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (out_valid && !out_ready && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (flush && !(&flush_cnt_q)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
